// File: rtl/load_store_unit.sv
// load_store_unit: single-request RV32I load/store engine in front of a
// word-wide data memory with combinational read and clocked write.
//   CLK, rst            clock; asynchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_we, funct3      store/load select and RV32I size/sign code
//   addr, wdata         byte address and right-aligned store data
//   resp_valid          one-cycle completion pulse
//   resp_err, rdata     error flag and extended load data, held until next response
//   mem_A/mem_WD/mem_WE memory address, write word, write enable
//   mem_RD              memory read word (combinational from mem_A)
// Sub-word stores are read-modify-write: the word is read, the lane is
// replaced, and the merged word is written back in a single STORE cycle.
module load_store_unit #(
  parameter int unsigned WORD_ADDR = 0
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] rdata,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, RESP} state_t;

  state_t      state, state_next;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;     // store word: wdata for SW, merged word for SB/SH
  logic        req_bad;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic [31:0] addr_map;

  // Illegal funct3 or misaligned access, decoded from the live request.
  always_comb begin
    logic legal;
    logic misaligned;
    legal = 1'b0;
    if (req_we) begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    req_bad = !legal || misaligned;
  end

  // Little-endian lane extraction with sign/zero extension.
  always_comb begin
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    byte_sh  = mem_RD >> {addr_q[1:0], 3'b000};
    half_sh  = addr_q[1] ? {16'h0000, mem_RD[31:16]} : {16'h0000, mem_RD[15:0]};
    load_val = '0;
    case (f3_q)
      3'b000:  load_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  load_val = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b010:  load_val = mem_RD;
      3'b100:  load_val = {24'h000000, byte_sh[7:0]};
      3'b101:  load_val = {16'h0000, half_sh[15:0]};
      default: load_val = '0;
    endcase
  end

  // Read word with the addressed byte/halfword replaced by store data.
  always_comb begin
    merged = mem_RD;
    if (f3_q[0]) begin
      if (addr_q[1]) merged[31:16] = wd_q[15:0];
      else           merged[15:0]  = wd_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'b00:   merged[7:0]   = wd_q[7:0];
        2'b01:   merged[15:8]  = wd_q[7:0];
        2'b10:   merged[23:16] = wd_q[7:0];
        default: merged[31:24] = wd_q[7:0];
      endcase
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad)                  state_next = RESP;
          else if (!req_we)             state_next = LOAD;
          else if (funct3 == 3'b010)    state_next = STORE;
          else                          state_next = RMW_RD;
        end
      end
      LOAD:    state_next = RESP;
      RMW_RD:  state_next = STORE;
      STORE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
      rdata    <= '0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q   <= req_we;
            f3_q   <= funct3;
            addr_q <= addr;
            wd_q   <= wdata;
            if (req_bad) begin
              resp_err <= 1'b1;
              rdata    <= '0;
            end
          end
        end
        LOAD: begin
          rdata    <= load_val;
          resp_err <= 1'b0;
        end
        RMW_RD: wd_q <= merged;
        STORE: begin
          rdata    <= '0;
          resp_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign addr_map = (WORD_ADDR != 0) ? {2'b00, addr_q[31:2]} : {addr_q[31:2], 2'b00};

  // State resets asynchronously, so mem_WE falls the moment rst rises.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_WE     = (state == STORE);
    mem_WD     = (state == STORE) ? wd_q : '0;
    mem_A      = ((state == LOAD) || (state == RMW_RD) || (state == STORE)) ? addr_map : '0;
  end

  logic unused_we;
  assign unused_we = we_q;

endmodule
